// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_wb_stage
// Purpose  : MEM -> WB pipeline register. Captures the MEM-stage register
//            write request and aligns/extends load data (LB/LBU/LH/LHU/LW,
//            big-endian byte lanes). Produces the registered we/waddr/wdata
//            triple used by the register file in the WB cycle. Misaligned
//            loads are dropped and reported on a one-cycle wb_adel pulse.
// Ports    : clk, rst (async, active-high)
//            stall_mem, stall_wb, flush       - pipeline control
//            mem_we, mem_waddr, mem_wdata     - MEM-stage write request
//            mem_ldop, mem_addr_lo, mem_rdata - load type, offset, memory word
//            wb_we, wb_waddr, wb_wdata        - registered write triple
//            wb_adel                          - misaligned-load pulse
//            wb_valid                         - WB holds a real instruction
//            With MEM_WB_HILO_EN defined, also:
//            mem_whilo, mem_hi, mem_lo -> wb_whilo, wb_hi, wb_lo
// Macro    : MEM_WB_HILO_EN (optional HI/LO write path)
// Revision : 1.0 - initial release
// ============================================================================
module mem_wb_stage #(
    parameter int DATA_W = 32,  // only 32 is supported
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_mem,
    input  logic              stall_wb,
    input  logic              flush,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [2:0]        mem_ldop,
    input  logic [1:0]        mem_addr_lo,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_WB_HILO_EN
    input  logic              mem_whilo,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    output logic              wb_whilo,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
`endif
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_waddr,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              wb_adel,
    output logic              wb_valid
);

    localparam logic [2:0] c_LD_LB  = 3'b001;
    localparam logic [2:0] c_LD_LBU = 3'b010;
    localparam logic [2:0] c_LD_LH  = 3'b011;
    localparam logic [2:0] c_LD_LHU = 3'b100;
    localparam logic [2:0] c_LD_LW  = 3'b101;

    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_ext;
    logic              w_mis;
    logic [DATA_W-1:0] w_cap_data;

    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_adel;
    logic              r_valid;

    // Big-endian lane selection: offset 0 is the most significant byte.
    always_comb begin
        w_byte = mem_rdata[31:24];
        case (mem_addr_lo)
            2'd0: w_byte = mem_rdata[31:24];
            2'd1: w_byte = mem_rdata[23:16];
            2'd2: w_byte = mem_rdata[15:8];
            2'd3: w_byte = mem_rdata[7:0];
            default: w_byte = mem_rdata[31:24];
        endcase
        // Bit 0 of the offset is irrelevant here; odd offsets are caught as misaligned.
        w_half = mem_addr_lo[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    end

    always_comb begin
        w_ext = mem_wdata;
        case (mem_ldop)
            c_LD_LB:  w_ext = {{24{w_byte[7]}}, w_byte};
            c_LD_LBU: w_ext = {24'd0, w_byte};
            c_LD_LH:  w_ext = {{16{w_half[15]}}, w_half};
            c_LD_LHU: w_ext = {16'd0, w_half};
            c_LD_LW:  w_ext = mem_rdata;
            default:  w_ext = mem_wdata;  // none, and the reserved codes 110/111
        endcase
    end

    always_comb begin
        w_mis = 1'b0;
        if ((mem_ldop == c_LD_LH) || (mem_ldop == c_LD_LHU))
            w_mis = mem_addr_lo[0];
        else if (mem_ldop == c_LD_LW)
            w_mis = (mem_addr_lo != 2'd0);
        w_cap_data = w_mis ? '0 : w_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_adel  <= 1'b0;
            r_valid <= 1'b0;
        end else if (flush || (stall_mem && !stall_wb)) begin
            // Bubble: flush wins over every stall combination.
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_adel  <= 1'b0;
            r_valid <= 1'b0;
        end else if (stall_mem) begin
            // Both stages held: keep the instruction but never re-issue the
            // misaligned-load pulse.
            r_adel  <= 1'b0;
        end else begin
            r_we    <= mem_we & ~w_mis;
            r_waddr <= mem_waddr;
            r_wdata <= w_cap_data;
            r_adel  <= mem_we & w_mis;
            r_valid <= 1'b1;
        end
    end

    assign wb_we    = r_we;
    assign wb_waddr = r_waddr;
    assign wb_wdata = r_wdata;
    assign wb_adel  = r_adel;
    assign wb_valid = r_valid;

`ifdef MEM_WB_HILO_EN
    logic              r_whilo;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    // HI/LO follow the same bubble/hold/capture rules; load alignment never touches them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_whilo <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (flush || (stall_mem && !stall_wb)) begin
            r_whilo <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else if (!stall_mem) begin
            r_whilo <= mem_whilo;
            r_hi    <= mem_hi;
            r_lo    <= mem_lo;
        end
    end

    assign wb_whilo = r_whilo;
    assign wb_hi    = r_hi;
    assign wb_lo    = r_lo;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_wb_stage
// Purpose  : Self-checking bench for mem_wb_stage. Directed vectors push a
//            hand-computed expected WB state into a scoreboard queue; a
//            monitor pops one entry after each rising edge and compares.
//            Reset behaviour is checked directly around the reset pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        adel;
        logic        valid;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_mem = 1'b0, stall_wb = 1'b0, flush = 1'b0;
    logic        mem_we = 1'b0;
    logic [4:0]  mem_waddr = '0;
    logic [31:0] mem_wdata = '0;
    logic [2:0]  mem_ldop = '0;
    logic [1:0]  mem_addr_lo = '0;
    logic [31:0] mem_rdata = '0;
    logic        mem_whilo = 1'b0;
    logic [31:0] mem_hi = '0, mem_lo = '0;
    logic        wb_we, wb_adel, wb_valid;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi, wb_lo;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    exp_t sb[$];

    mem_wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .stall_mem(stall_mem), .stall_wb(stall_wb), .flush(flush),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_ldop(mem_ldop), .mem_addr_lo(mem_addr_lo), .mem_rdata(mem_rdata),
`ifdef MEM_WB_HILO_EN
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
`endif
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .wb_adel(wb_adel), .wb_valid(wb_valid)
    );

`ifndef MEM_WB_HILO_EN
    assign wb_whilo = 1'b0;
    assign wb_hi    = '0;
    assign wb_lo    = '0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic adel, input logic valid);
        exp_t e;
        e.we = we; e.waddr = wa; e.wdata = wd; e.adel = adel; e.valid = valid;
        e.whilo = 1'b0; e.hi = '0; e.lo = '0;
        return e;
    endfunction

    // Drive one cycle of MEM inputs and queue the WB state expected after the next edge.
    task automatic step(input logic fl, input logic sm, input logic sw,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [2:0] op, input logic [1:0] lo, input logic [31:0] rd,
                        input exp_t e);
        @(negedge clk);
        flush = fl; stall_mem = sm; stall_wb = sw;
        mem_we = we; mem_waddr = wa; mem_wdata = wd;
        mem_ldop = op; mem_addr_lo = lo; mem_rdata = rd;
        sb.push_back(e);
    endtask

    // Monitor: one popped expectation per rising edge while out of reset.
    always @(posedge clk) begin
        exp_t e;
        string tag;
        #1;
        if (!rst && sb.size() > 0) begin
            e = sb.pop_front();
            pops++;
            tag = $sformatf("cyc%0d", pops);
            chk({tag, "_we"},    {31'd0, wb_we},    {31'd0, e.we});
            chk({tag, "_waddr"}, {27'd0, wb_waddr}, {27'd0, e.waddr});
            chk({tag, "_wdata"}, wb_wdata,          e.wdata);
            chk({tag, "_adel"},  {31'd0, wb_adel},  {31'd0, e.adel});
            chk({tag, "_valid"}, {31'd0, wb_valid}, {31'd0, e.valid});
`ifdef MEM_WB_HILO_EN
            chk({tag, "_whilo"}, {31'd0, wb_whilo}, {31'd0, e.whilo});
            chk({tag, "_hi"},    wb_hi,             e.hi);
            chk({tag, "_lo"},    wb_lo,             e.lo);
`endif
        end
    end

    task automatic chk_zero(input string name);
        chk({name, "_we"},    {31'd0, wb_we},    32'd0);
        chk({name, "_waddr"}, {27'd0, wb_waddr}, 32'd0);
        chk({name, "_wdata"}, wb_wdata,          32'd0);
        chk({name, "_adel"},  {31'd0, wb_adel},  32'd0);
        chk({name, "_valid"}, {31'd0, wb_valid}, 32'd0);
    endtask

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        exp_t e;
        // Reset held across edges with busy inputs: outputs stay at zero.
        mem_we = 1'b1; mem_waddr = 5'd3; mem_wdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset_hold");
        rst = 1'b0;

        // Loads: LB/LBU offset 1 of 0x12F45678 -> byte 0xF4.
        step(0,0,0, 1,5'd7,32'h0, 3'b001,2'd1,32'h12F45678, mk(1,5'd7,32'hFFFFFFF4,0,1));
        step(0,0,0, 1,5'd7,32'h0, 3'b010,2'd1,32'h12F45678, mk(1,5'd7,32'h000000F4,0,1));
        // Halfwords and word from 0xAAAA8001.
        step(0,0,0, 1,5'd3,32'h0, 3'b011,2'd2,32'hAAAA8001, mk(1,5'd3,32'hFFFF8001,0,1));
        step(0,0,0, 1,5'd3,32'h0, 3'b100,2'd0,32'hAAAA8001, mk(1,5'd3,32'h0000AAAA,0,1));
        step(0,0,0, 1,5'd3,32'h0, 3'b101,2'd0,32'hAAAA8001, mk(1,5'd3,32'hAAAA8001,0,1));
        // Misaligned LW: dropped, adel pulses for one cycle.
        step(0,0,0, 1,5'd5,32'h0, 3'b101,2'd2,32'hAAAA8001, mk(0,5'd5,32'h0,1,1));
        // Lowest byte lane, sign bit set; positive halfword at offset 0.
        step(0,0,0, 1,5'd6,32'h0, 3'b001,2'd3,32'h00000080, mk(1,5'd6,32'hFFFFFF80,0,1));
        step(0,0,0, 1,5'd6,32'h0, 3'b011,2'd0,32'h7FFF0000, mk(1,5'd6,32'h00007FFF,0,1));
        // Reserved ldop behaves as none; odd offset is not misaligned then.
        step(0,0,0, 1,5'd8,32'h1234ABCD, 3'b110,2'd1,32'hFFFFFFFF, mk(1,5'd8,32'h1234ABCD,0,1));
        // Misaligned LH followed by a full hold: adel must not persist.
        step(0,0,0, 1,5'd4,32'h0, 3'b011,2'd1,32'h11223344, mk(0,5'd4,32'h0,1,1));
        step(0,1,1, 1,5'd4,32'h0, 3'b011,2'd1,32'h11223344, mk(0,5'd4,32'h0,0,1));
        // ALU result to r9, then held three cycles while MEM inputs change.
        e = mk(1,5'd9,32'hDEADBEEF,0,1);
        e.whilo = 1'b1; e.hi = 32'h1; e.lo = 32'h2;
        @(negedge clk);
        mem_whilo = 1'b1; mem_hi = 32'h1; mem_lo = 32'h2;
        step(0,0,0, 1,5'd9,32'hDEADBEEF, 3'b000,2'd0,32'h0, e);
        step(0,1,1, 1,5'd1,32'h11111111, 3'b000,2'd0,32'h0, e);
        @(negedge clk);
        mem_whilo = 1'b0; mem_hi = 32'h5; mem_lo = 32'h6;
        step(0,1,1, 0,5'd2,32'h22222222, 3'b101,2'd0,32'h9, e);
        step(0,1,1, 1,5'd3,32'h33333333, 3'b001,2'd2,32'h9, e);
        // MEM stalled, WB free: bubble.
        step(0,1,0, 1,5'd3,32'h33333333, 3'b000,2'd0,32'h0, mk(0,5'd0,32'h0,0,0));
        // Write to r0 is captured and never raises adel.
        @(negedge clk);
        mem_whilo = 1'b0; mem_hi = 32'h0; mem_lo = 32'h0;
        step(0,0,0, 1,5'd0,32'h00000055, 3'b000,2'd0,32'h0, mk(1,5'd0,32'h00000055,0,1));
        // Flush overrides a full hold.
        step(1,1,1, 1,5'd12,32'hCAFEF00D, 3'b000,2'd0,32'h0, mk(0,5'd0,32'h0,0,0));
        // stall_wb alone does not block capture.
        step(0,0,1, 1,5'd2,32'h00000077, 3'b000,2'd0,32'h0, mk(1,5'd2,32'h00000077,0,1));
        // Full hold so the captured r2 remains, then async reset mid-cycle.
        step(0,1,1, 1,5'd2,32'h00000077, 3'b000,2'd0,32'h0, mk(1,5'd2,32'h00000077,0,1));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        @(negedge clk);
        chk_zero("rst_mid_stall");
        // Release with inputs idle, then confirm normal capture resumes.
        stall_mem = 1'b0; stall_wb = 1'b0;
        rst = 1'b0;
        step(0,0,0, 1,5'd10,32'h0, 3'b100,2'd2,32'h0000C3A5, mk(1,5'd10,32'h0000C3A5,0,1));
        step(0,0,0, 0,5'd0,32'h0, 3'b000,2'd0,32'h0, mk(0,5'd0,32'h0,0,1));
        @(posedge clk);
        #3;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
